// File: rtl/fp_recode_pkg.sv
// Shared types and helpers for the IEEE recode pipeline.
// Class flags are one-hot apart from snan, which always rides with nan.
package fp_recode_pkg;

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;
        logic normal;
        logic subnormal;
    } fp_flags_t;

    localparam fp_flags_t CLS_NONE   = 6'b000000;
    localparam fp_flags_t CLS_QNAN   = 6'b100000;
    localparam fp_flags_t CLS_SNAN   = 6'b110000;
    localparam fp_flags_t CLS_INF    = 6'b001000;
    localparam fp_flags_t CLS_ZERO   = 6'b000100;
    localparam fp_flags_t CLS_NORMAL = 6'b000010;
    localparam fp_flags_t CLS_SUB    = 6'b000001;

    function automatic logic [31:0] exp_all_ones(input int ew);
        return (32'h1 << ew) - 32'h1;
    endfunction

    // FP32 instance of the recoded result; other widths declare the
    // same layout locally from their EXP_W/FRAC_W.
    typedef struct packed {
        logic      sign;
        logic [8:0] exp;
        logic [23:0] sig;
        fp_flags_t flags;
    } fp32_rec_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; all-zero input yields W.
module fp_lzc #(
    parameter int W  = 23,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data,
    output logic [CW-1:0] count
);

    // Upward scan: the highest set bit writes last and wins.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (data[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_recode_pipe.sv
// Two-stage IEEE classify/recode pipeline with valid/ready on both sides.
// Stage 1 classifies and counts zeros, stage 2 recodes and holds output.
module fp_recode_pipe
    import fp_recode_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int W      = EXP_W + FRAC_W + 1,
    parameter int BIAS   = (1 << (EXP_W - 1)) - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_fp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W:0]    out_exp,
    output logic [FRAC_W:0]   out_sig,
    output logic              out_is_nan,
    output logic              out_is_snan,
    output logic              out_is_inf,
    output logic              out_is_zero,
    output logic              out_is_normal,
    output logic              out_is_subnormal,
    input  logic              clr_sticky,
    output logic              snan_sticky
);

    localparam int LZ_W = $clog2(FRAC_W + 1);
    localparam int XW   = EXP_W + 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W:0]    exp;
        logic [FRAC_W:0]   sig;
        fp_flags_t         flags;
    } rec_t;

    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [FRAC_W-1:0] in_frac;
    logic [LZ_W-1:0]   in_lz;
    fp_flags_t         in_cls;
    logic              exp_zero;
    logic              exp_ones;
    logic              frac_zero;

    logic              s1_valid;
    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [FRAC_W-1:0] s1_frac;
    logic [LZ_W-1:0]   s1_lz;
    fp_flags_t         s1_cls;

    logic              s1_adv;
    logic              s2_adv;
    logic              s2_valid;
    rec_t              rec;
    rec_t              out_q;

    assign {in_sign, in_exp, in_frac} = in_fp;

    fp_lzc #(.W(FRAC_W)) u_lzc (
        .data  (in_frac),
        .count (in_lz)
    );

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        exp_zero  = (in_exp == '0);
        exp_ones  = (in_exp == EXP_W'(exp_all_ones(EXP_W)));
        frac_zero = (in_frac == '0);
        in_cls    = CLS_NORMAL;
        unique case (1'b1)
            exp_zero && frac_zero:  in_cls = CLS_ZERO;
            exp_zero && !frac_zero: in_cls = CLS_SUB;
            exp_ones && frac_zero:  in_cls = CLS_INF;
            exp_ones && !frac_zero && !in_frac[FRAC_W-1]:
                in_cls = CLS_SNAN;
            exp_ones && !frac_zero && in_frac[FRAC_W-1]:
                in_cls = CLS_QNAN;
            default: in_cls = CLS_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_frac  <= '0;
            s1_lz    <= '0;
            s1_cls   <= CLS_NONE;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_exp  <= in_exp;
                s1_frac <= in_frac;
                s1_lz   <= in_lz;
                s1_cls  <= in_cls;
            end
        end
    end

    // Subnormals: shifting past the leading zeros plus the hidden
    // position lands the first set bit on sig[FRAC_W].
    always_comb begin
        rec       = '0;
        rec.sign  = s1_sign;
        rec.flags = s1_cls;
        unique case (1'b1)
            s1_cls.normal: begin
                rec.exp = {1'b0, s1_exp} - XW'(BIAS);
                rec.sig = {1'b1, s1_frac};
            end
            s1_cls.subnormal: begin
                rec.exp = -XW'(BIAS) - XW'(s1_lz);
                rec.sig = {s1_frac, 1'b0} << s1_lz;
            end
            s1_cls.nan: rec.sig = {1'b0, s1_frac};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_q    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) out_q <= rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snan_sticky <= 1'b0;
        end else if (s2_valid && out_ready && out_q.flags.snan) begin
            snan_sticky <= 1'b1;
        end else if (clr_sticky) begin
            snan_sticky <= 1'b0;
        end
    end

    assign out_valid        = s2_valid;
    assign out_sign         = out_q.sign;
    assign out_exp          = out_q.exp;
    assign out_sig          = out_q.sig;
    assign out_is_nan       = out_q.flags.nan;
    assign out_is_snan      = out_q.flags.snan;
    assign out_is_inf       = out_q.flags.inf;
    assign out_is_zero      = out_q.flags.zero;
    assign out_is_normal    = out_q.flags.normal;
    assign out_is_subnormal = out_q.flags.subnormal;

endmodule

// File: doc/fp_recode_pipe.md
Name: fp_recode_pipe

Overview:
- Parametrised, pipelined successor to the FP32 recode/classify block.
- Converts an IEEE-754 binary value of any EXP_W/FRAC_W into the team's recoded form:
  - sign;
  - signed unbiased exponent, EXP_W+1 bits;
  - significand with explicit leading one, FRAC_W+1 bits, with subnormals normalised;
  - one-hot class flags.
- Two-stage pipeline with valid/ready handshake on both sides.
- Sticky signalling-NaN flag for the FPU status logic.
- Sits between the operand register file and the FPU arithmetic units.

Parameters:
- EXP_W, 8, exponent field width; FP32 default; must satisfy FRAC_W+BIAS < 2^EXP_W.
- FRAC_W, 23, fraction field width.
- W, EXP_W+FRAC_W+1, derived input width; must not be overridden.
- BIAS, 2^(EXP_W-1)-1, derived exponent bias.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts input this cycle.
- in_fp  in  W  IEEE word {sign, exp_field, frac}.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sign  out  1  sign bit, passed through.
- out_exp  out  EXP_W+1  signed two's-complement unbiased exponent.
- out_sig  out  FRAC_W+1  significand, bit FRAC_W is the leading one.
- out_is_nan  out  1  NaN, quiet or signalling.
- out_is_snan  out  1  signalling NaN: exp all ones, frac!=0, frac MSB=0.
- out_is_inf  out  1  infinity.
- out_is_zero  out  1  +/-0.
- out_is_normal  out  1  normal number.
- out_is_subnormal  out  1  subnormal number.
- clr_sticky  in  1  synchronous clear of snan_sticky.
- snan_sticky  out  1  set when an sNaN result is handed off.

Behaviour:
- Reset, asynchronous on rst_n low:
  - s1_valid, s2_valid, out_valid and snan_sticky go to 0.
  - All out_* data and flags go to 0.
  - in_ready reads 1 during reset.
  - An in-flight transaction is dropped on reset; it is never replayed.
- Handshake:
  - A transfer occurs when valid && ready.
  - out_valid, once high, holds and all out_* stay stable until out_ready.
  - in_valid high with in_ready low is not a transfer; the input is not latched.
- Pipeline:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational from out_ready; no skid buffer.
  - Latency is exactly 2 cycles with out_ready held high.
  - Throughput is 1 word per cycle.
  - Back-pressure stalls both stages without loss or duplication.
- Stage 1 (classify) registers sign, exp_field, frac, the class flags and lz.
  - lz = leading-zero count of frac, clog2(FRAC_W+1) bits.
  - Class rules:
    - exp_field==0 && frac==0: zero.
    - exp_field==0 && frac!=0: subnormal.
    - exp_field all ones && frac==0: inf.
    - exp_field all ones && frac!=0: nan; snan additionally if frac[FRAC_W-1]==0.
    - Otherwise: normal.
  - Exactly one of nan/inf/zero/normal/subnormal is 1 on any valid output.
- Stage 2 (recode):
  - normal: exp = exp_field-BIAS; sig = {1, frac}.
  - subnormal: exp = -BIAS-lz; sig = (frac << (lz+1)) truncated to FRAC_W+1 bits, so bit FRAC_W = 1.
  - zero and inf: exp = 0; sig = 0.
  - nan: exp = 0; sig = {0, frac}, payload preserved.
  - All exponent arithmetic is signed, EXP_W+1 bits. No overflow is possible under the parameter constraint.
- snan_sticky:
  - Set on a cycle where out_valid && out_ready && out_is_snan.
  - Cleared by clr_sticky.
  - If set and clear occur in the same cycle, set wins.
- Output fields are undefined-but-stable while out_valid is 0; they are held at their last values.

Decomposition:
- Package fp_recode_pkg holds:
  - the class encoding constants;
  - a function exp_all_ones(EXP_W);
  - a parametrised struct typedef for the recoded result {sign, exp, sig, flags}, shared with downstream units.
- Sub-module fp_lzc: parametrised leading-zero counter of width FRAC_W, combinational.
  - Output is FRAC_W when the input is all zero.
  - Instantiated in stage 1.

Test Plan:
1. FP32, out_ready=1, in_fp=32'hFF800000 → 2 cycles later: out_sign=1, out_is_inf=1, out_exp=0, out_sig=0.
2. FP32, in_fp=32'h3F800000 (1.0) → out_exp=9'h000, out_sig=24'h800000, out_is_normal=1. In the next cycle 32'h00000001 → out_is_subnormal=1, out_exp=9'h16B (-149), out_sig=24'h800000. In the next cycle 32'h00400000 → out_exp=-127 (9'h181), out_sig=24'h800000.
3. FP32, in_fp=32'h7FA00000 → out_is_nan=1, out_is_snan=1, out_sig=24'h200000. snan_sticky=1 after handoff. 32'h7FC00000 → out_is_snan=0. Pulse clr_sticky → snan_sticky=0. Set and clear together → stays 1.
4. Back-pressure: stream 5 distinct words with out_ready random at 50%; hold out_ready=0 for 4 cycles → in_ready=0 once both stages are full. Outputs are in order, no loss, no duplicates, stable while stalled.
5. Reset mid-operation: assert rst_n=0 with both stages full → out_valid=0 asynchronously, snan_sticky=0. After release, first output appears 2 cycles after the next accepted input.
6. Parameters EXP_W=5, FRAC_W=10 (FP16): 16'h0001 → out_exp=6'b101000 (-24), out_sig=11'h400, subnormal. 16'h7C00 → inf. 16'h0000 → zero.
